// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the MEM-stage pipeline logic and data_memory_ctrl.
// The master issues load/store requests; the slave (the memory) returns the registered response.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              load_unsigned;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              valid;
  logic              misaligned;
  logic              out_of_range;
  logic              ready;

  modport master (
    output mem_read, mem_write, size, load_unsigned, address, write_data,
    input  read_data, valid, misaligned, out_of_range, ready
  );

  modport slave (
    input  mem_read, mem_write, size, load_unsigned, address, write_data,
    output read_data, valid, misaligned, out_of_range, ready
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the MEM stage: byte/half/word loads and stores,
// registered response with error flags, and a post-reset clear sweep over every word.
module data_memory_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  data_memory_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so the range limit never truncates for small ADDR_W.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]  read_data_reg, read_data_next;
  logic               valid_reg, valid_next;
  logic               misaligned_reg, misaligned_next;
  logic               oor_reg, oor_next;

  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         lane;
  logic               req_misaligned;
  logic               req_oor;
  logic               req_any;
  logic               do_store;
  logic               do_load;
  logic [3:0]         mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [3:0][7:0]    mem_wdata;
  logic [DATA_W-1:0]  rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [DATA_W-1:0]  load_data;

  assign word_idx = bus.address[IDX_W+1:2];
  assign lane     = bus.address[1:0];

  assign req_misaligned = (bus.size == 2'b11)
                        | ((bus.size == 2'b01) & bus.address[0])
                        | ((bus.size == 2'b10) & (|bus.address[1:0]));
  assign req_oor  = ({1'b0, bus.address} >= LIMIT);

  assign req_any  = (state_reg == ST_READY) & (bus.mem_read | bus.mem_write);
  assign do_store = req_any & bus.mem_write & ~req_misaligned & ~req_oor;
  assign do_load  = req_any & ~bus.mem_write & ~req_misaligned & ~req_oor;

  // Write port: clear sweep during INIT, lane-enabled store in READY.
  always_comb begin
    mem_we    = 4'b0000;
    mem_idx   = word_idx;
    mem_wdata = bus.write_data;
    if (state_reg == ST_INIT) begin
      mem_we    = 4'b1111;
      mem_idx   = cnt_reg;
      mem_wdata = '0;
    end else if (do_store) begin
      case (bus.size)
        2'b00: begin
          mem_we    = 4'b0001 << lane;
          mem_wdata = {4{bus.write_data[7:0]}};
        end
        2'b01: begin
          mem_we    = bus.address[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{bus.write_data[15:0]}};
        end
        default: begin
          mem_we    = 4'b1111;
          mem_wdata = bus.write_data;
        end
      endcase
    end
    // A store landing on the same edge as reset assertion must be dropped.
    if (!rst) begin
      mem_we = 4'b0000;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we[gi]) begin
          lane_mem[mem_idx] <= mem_wdata[gi];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = bus.address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (bus.size)
      2'b00:   load_data = {{(DATA_W-8){~bus.load_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{(DATA_W-16){~bus.load_unsigned & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    valid_next      = req_any;
    misaligned_next = req_any & req_misaligned;
    oor_next        = req_any & req_oor;
    read_data_next  = read_data_reg;
    if (do_load) begin
      read_data_next = load_data;
    end else if (req_any) begin
      read_data_next = '0;
    end
    if (state_reg == ST_INIT) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == IDX_W'(DEPTH - 1)) begin
        state_next = ST_READY;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_INIT;
      cnt_reg        <= '0;
      read_data_reg  <= '0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      oor_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      read_data_reg  <= read_data_next;
      valid_reg      <= valid_next;
      misaligned_reg <= misaligned_next;
      oor_reg        <= oor_next;
    end
  end

  assign bus.read_data    = read_data_reg;
  assign bus.valid        = valid_reg;
  assign bus.misaligned   = misaligned_reg;
  assign bus.out_of_range = oor_reg;
  assign bus.ready        = (state_reg == ST_READY);
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised byte-addressable data memory for the MIPS pipeline MEM stage. It supersedes the fixed 10-word data memory with a configurable depth and width and adds byte, halfword and word load/store with sign or zero extension. It also adds a registered read response with a valid strobe, alignment and range checking, and a post-reset clear sequencer. The block sits between the EX/MEM pipeline register and the MEM/WB write-back mux.

Parameters:
DATA_W, 32, word width in bits; must be 32 (byte lanes fixed at 4).
DEPTH, 64, number of words; power of two, 4 to 1024.
ADDR_W, 32, width of the byte address input.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
i_mem_read  input  1  load request this cycle.
i_mem_write  input  1  store request this cycle.
i_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
i_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
i_address  input  ADDR_W  byte address, little-endian lanes.
i_write_data  input  DATA_W  store data; byte/half taken from the LSBs.
o_read_data  output  DATA_W  registered load result.
o_valid  output  1  one-cycle pulse: response to the request of the previous cycle (load or store).
o_misaligned  output  1  registered with o_valid; the request was misaligned or used a reserved size.
o_out_of_range  output  1  registered with o_valid; the address was >= DEPTH*4.
o_ready  output  1  1 when requests are accepted (state READY).

Behaviour:
- Reset (rst=0, async): o_read_data=0, o_valid=0, o_misaligned=0, o_out_of_range=0, o_ready=0, clear counter=0, state=INIT. Memory contents are not reset asynchronously.
- FSM INIT: on rst release, write 0 to word[cnt] each cycle, cnt=0..DEPTH-1. When cnt==DEPTH-1, go to READY next cycle. INIT lasts exactly DEPTH cycles. Requests during INIT are ignored: no write, no o_valid.
- FSM READY: o_ready=1. Stays in READY until rst is asserted.
- Reset mid-INIT or mid-access: everything returns to reset values and INIT restarts from cnt=0. A store in the same edge as rst assertion is lost.
- Word index = i_address[log2(DEPTH)+1:2]. Byte lane = i_address[1:0].
- Out of range: i_address >= DEPTH*4.
- Misaligned:
  - halfword with i_address[0]=1;
  - word with i_address[1:0]!=0;
  - i_size=11.
- Error handling: an erroring request performs no write. It still produces o_valid=1 next cycle with the matching flag(s) set and o_read_data=0. Both flags may be 1 together.
- Store (READY, i_mem_write=1, no error): on the rising edge, update only the addressed lanes.
  - byte: lane = addr[1:0], data = i_write_data[7:0].
  - half: lanes {addr[1],0} and {addr[1],1}, data = i_write_data[15:0].
  - word: all 4 lanes.
  - Next cycle: o_valid=1, o_read_data=0.
- Load (READY, i_mem_read=1, no error): latency 1. At the edge, o_read_data is loaded with the selected lane(s) right-justified and extended per i_unsigned (word ignores i_unsigned). o_valid=1 for one cycle.
- Read-after-write: a load in the cycle after a store to the same word returns the updated data.
- i_mem_read and i_mem_write both 1: treated as a store only. The response is as for a store.
- No request in READY: o_valid=0 next cycle. o_read_data holds its last value. Flags clear to 0.
- Width rule: all extension is to DATA_W. Address bits above the range check are compared in full ADDR_W width, with no truncation.

Test Plan:
- Reset/INIT: rst=0 for 3 cycles, then release with DEPTH=64 -> o_ready=0 for exactly 64 cycles, then 1. A load of word at addr 0x3C returns 0x00000000, o_valid=1, flags=0.
- Word store/load: store 0x8badf00d at 0x10 (size 10), next cycle load 0x10 -> o_read_data=0x8badf00d one cycle after the load, o_valid single pulse.
- Byte/half lanes and extension: after the previous scenario:
  - load byte 0x13 signed -> 0xffffff8b;
  - load byte 0x13 unsigned -> 0x0000008b;
  - load half 0x10 signed -> 0xfffff00d.
  - Then store byte 0xAA at 0x11 and reload word 0x10 -> 0x8badaa0d.
- Errors:
  - load word at 0x12 -> o_misaligned=1, o_read_data=0;
  - store at 0x100 (DEPTH=64) -> o_out_of_range=1, memory unchanged;
  - half at 0x101 -> both flags=1.
- Simultaneous read+write to 0x20 with data 0x12345678 -> store performed, o_read_data=0. A subsequent load returns 0x12345678.
- Reset mid-INIT: assert rst at INIT cycle 20 -> all outputs 0 immediately (async). After release, o_ready rises after a full 64 cycles.
